snoop_arbiter: RTL and testbench
================================

# snoop_arbiter

Shares one packet snooper among N_SN packet-memory agents (circular buffers / filter cores) so several buffers can be filled in turn from a single ingress stream. Sits between the snooper's buffer-side handshake (rdy_for_sn / rdy_for_sn_ack / sn_done) and the per-agent copies of that handshake. Buffers are granted round-robin, one packet at a time, and the snooper's write bus is steered to the granted agent. The block also accumulates the snooper's dropped-packet pulses.

## Interface
Parameters:
- N_SN, 4, number of agents (2..16)
- SN_FWD_DATA_WIDTH, 64, write data width
- SN_FWD_ADDR_WIDTH, 9, write address width
- SN_INC_WIDTH, 3, byte-increment width
- DROP_CNT_WIDTH, 32, drop counter width

Ports:
- clk  in  1  single clock; all state on posedge
- rst  in  1  asynchronous, active-low reset
- sn_addr  in  SN_FWD_ADDR_WIDTH  snooper write address
- sn_wr_data  in  SN_FWD_DATA_WIDTH  snooper write data
- sn_wr_en  in  1  snooper write enable
- sn_byte_inc  in  SN_INC_WIDTH  snooper byte increment
- sn_done  in  1  snooper end-of-packet pulse
- rdy_for_sn  out  1  offer of a free buffer to the snooper
- rdy_for_sn_ack  in  1  snooper accepts offer
- packet_dropped_inc  in  1  snooper drop pulse
- ag_rdy_for_sn  in  N_SN  per-agent buffer-free request
- ag_rdy_for_sn_ack  out  N_SN  per-agent accept
- ag_addr  out  N_SN*SN_FWD_ADDR_WIDTH  per-agent address, agent i at slice i
- ag_wr_data  out  N_SN*SN_FWD_DATA_WIDTH  per-agent data
- ag_wr_en  out  N_SN  per-agent write enable
- ag_byte_inc  out  N_SN*SN_INC_WIDTH  per-agent byte increment
- ag_sn_done  out  N_SN  per-agent done pulse
- sel  out  clog2(N_SN)  currently granted agent
- drop_count  out  DROP_CNT_WIDTH  saturating drop count

## Operation
- FSM with three states: IDLE, OFFER, BUSY.
- IDLE: if any ag_rdy_for_sn bit is set, pick the first set bit searching upward from last+1 (mod N_SN). Register it in sel and go to OFFER. Otherwise stay in IDLE.
- OFFER: rdy_for_sn=1. When rdy_for_sn_ack=1, ag_rdy_for_sn_ack[sel]=1 in the same cycle (combinational), last<=sel, and the FSM goes to BUSY.
- BUSY: rdy_for_sn=0. Outputs to agent sel: ag_wr_en[sel]=sn_wr_en, address/data/byte_inc slices copied from the snooper inputs. All other ag_wr_en bits are 0. Data/address slices of non-selected agents are don't-care; drive them with the snooper values.
- BUSY, sn_done=1: ag_sn_done[sel]=1 in the same cycle, then go to IDLE.
- Agents hold ag_rdy_for_sn until acked. A request withdrawn in OFFER is a protocol violation; the offer stays up regardless.
- sn_wr_en or sn_done outside BUSY is ignored. No ag_* write or done output is driven.
- drop_count increments on each cycle with packet_dropped_inc=1, in any state. It saturates at all-ones.

## Timing
- Reset values: FSM=IDLE, sel=0, last=N_SN-1 (agent 0 has first priority), drop_count=0. All outputs 0.
- Reset asserted mid-packet: FSM goes to IDLE immediately (asynchronous) and all ag_* outputs drop. The agent is not signalled done.
- Request seen in IDLE at edge k: rdy_for_sn=1 from cycle k+1.
- Ack path has 0 cycles of latency. Write-bus steering is combinational on registered sel and state, with 0 cycles of latency.
- The cycle after sn_done is IDLE. The next offer is up 2 cycles after sn_done at the earliest.
- The ack and sn_done in the same OFFER cycle: sn_done is ignored.

## Structure
- Shared package snoop_arb_pkg holds:
  - FSM state encoding (IDLE=2'd0, OFFER=2'd1, BUSY=2'd2)
  - SEL_WIDTH = clog2(N_SN)
  - the drop-counter saturation constant
- One sub-module, rr_picker: combinational round-robin. Inputs are the request vector and last; outputs are a valid flag and the index. It is reusable by future forwarder-side arbiters.

## Test plan
- Single agent: ag_rdy_for_sn=4'b0001, ack at cycle 3, 8 writes, sn_done → ag_rdy_for_sn_ack[0] pulses once, ag_wr_en[0] high 8 cycles, ag_sn_done[0]=1 once, other agents silent.
- Round-robin fairness: all four agents request continuously for 8 packets → grant order 0,1,2,3,0,1,2,3.
- Sparse requests after grant to agent 2: requests 4'b0101 → agent 0 is granted next (wrap-around), then agent 2.
- Stray inputs: sn_wr_en and sn_done pulsed while IDLE/OFFER → all ag_wr_en and ag_sn_done stay 0, FSM unchanged.
- Drop counter: DROP_CNT_WIDTH=4, 20 packet_dropped_inc pulses → drop_count=15 and holds.
- Reset mid-packet: rst low during BUSY after 3 writes → outputs 0 immediately. After release, a new request gets an offer starting from agent 0.

Source files
------------

// File: rtl/snoop_arb_pkg.sv
// snoop_arb_pkg: shared FSM encoding, select-width helper and drop-counter saturation constant
package snoop_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_t;

    // Width of an agent index for n agents (never below 1 bit).
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Drop counters up to this width saturate against a slice of DROP_SAT.
    localparam int DROP_SAT_MAX_WIDTH = 64;
    localparam logic [DROP_SAT_MAX_WIDTH-1:0] DROP_SAT = '1;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin, first set request searching upward from last+1 (mod N)
//   req   in  N  request vector
//   last  in  W  most recently served index
//   valid out 1  any request set
//   idx   out W  chosen index
module rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan from the farthest candidate down so the nearest one after last wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                valid = 1'b1;
                idx   = W'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/snoop_arbiter.sv
// snoop_arbiter: shares one packet snooper among N_SN buffer agents, round-robin, one packet per grant
//   clk, rst (async, active-low)
//   snooper side : sn_addr, sn_wr_data, sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn, rdy_for_sn_ack,
//                  packet_dropped_inc
//   agent side   : ag_rdy_for_sn, ag_rdy_for_sn_ack, ag_addr, ag_wr_data, ag_wr_en, ag_byte_inc, ag_sn_done
//   status       : sel (granted agent), drop_count (saturating)
module snoop_arbiter
    import snoop_arb_pkg::*;
#(
    parameter int N_SN              = 4,
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int SN_FWD_ADDR_WIDTH = 9,
    parameter int SN_INC_WIDTH      = 3,
    parameter int DROP_CNT_WIDTH    = 32,
    localparam int SEL_WIDTH        = sel_width(N_SN)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SN_FWD_ADDR_WIDTH-1:0]        sn_addr,
    input  logic [SN_FWD_DATA_WIDTH-1:0]        sn_wr_data,
    input  logic                                sn_wr_en,
    input  logic [SN_INC_WIDTH-1:0]             sn_byte_inc,
    input  logic                                sn_done,
    output logic                                rdy_for_sn,
    input  logic                                rdy_for_sn_ack,
    input  logic                                packet_dropped_inc,
    input  logic [N_SN-1:0]                     ag_rdy_for_sn,
    output logic [N_SN-1:0]                     ag_rdy_for_sn_ack,
    output logic [N_SN*SN_FWD_ADDR_WIDTH-1:0]   ag_addr,
    output logic [N_SN*SN_FWD_DATA_WIDTH-1:0]   ag_wr_data,
    output logic [N_SN-1:0]                     ag_wr_en,
    output logic [N_SN*SN_INC_WIDTH-1:0]        ag_byte_inc,
    output logic [N_SN-1:0]                     ag_sn_done,
    output logic [SEL_WIDTH-1:0]                sel,
    output logic [DROP_CNT_WIDTH-1:0]           drop_count
);

    state_t                    state_q, state_d;
    logic [SEL_WIDTH-1:0]      sel_q, sel_d;
    logic [SEL_WIDTH-1:0]      last_q, last_d;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                      pick_valid;
    logic [SEL_WIDTH-1:0]      pick_idx;
    logic                      busy;

    rr_picker #(.N(N_SN), .W(SEL_WIDTH)) u_pick (
        .req   (ag_rdy_for_sn),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d           = state_q;
        sel_d             = sel_q;
        last_d            = last_q;
        rdy_for_sn        = 1'b0;
        ag_rdy_for_sn_ack = '0;
        ag_wr_en          = '0;
        ag_sn_done        = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // sn_done arriving with the ack belongs to no packet and is dropped.
                rdy_for_sn = 1'b1;
                if (rdy_for_sn_ack) begin
                    ag_rdy_for_sn_ack[sel_q] = 1'b1;
                    last_d                   = sel_q;
                    state_d                  = BUSY;
                end
            end
            BUSY: begin
                ag_wr_en[sel_q] = sn_wr_en;
                if (sn_done) begin
                    ag_sn_done[sel_q] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop_count_d = (packet_dropped_inc && drop_count_q != DROP_SAT[DROP_CNT_WIDTH-1:0])
                          ? drop_count_q + 1'b1 : drop_count_q;

    // Buses are broadcast to every slice while busy; only ag_wr_en qualifies the target.
    assign busy        = (state_q == BUSY);
    assign ag_addr     = busy ? {N_SN{sn_addr}}     : '0;
    assign ag_wr_data  = busy ? {N_SN{sn_wr_data}}  : '0;
    assign ag_byte_inc = busy ? {N_SN{sn_byte_inc}} : '0;
    assign sel         = sel_q;
    assign drop_count  = drop_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_q       <= SEL_WIDTH'(N_SN - 1);
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_snoop_arbiter.sv
// tb_snoop_arbiter: directed vector table plus hand sequences for reset, drop saturation and round-robin
module tb_snoop_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 9;
    localparam int IW = 3;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   sn_addr;
    logic [DW-1:0]   sn_wr_data;
    logic            sn_wr_en;
    logic [IW-1:0]   sn_byte_inc;
    logic            sn_done;
    logic            rdy_for_sn;
    logic            rdy_for_sn_ack;
    logic            packet_dropped_inc;
    logic [N-1:0]    ag_rdy_for_sn;
    logic [N-1:0]    ag_rdy_for_sn_ack;
    logic [N*AW-1:0] ag_addr;
    logic [N*DW-1:0] ag_wr_data;
    logic [N-1:0]    ag_wr_en;
    logic [N*IW-1:0] ag_byte_inc;
    logic [N-1:0]    ag_sn_done;
    logic [1:0]      sel;
    logic [CW-1:0]   drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    snoop_arbiter #(
        .N_SN(N), .SN_FWD_DATA_WIDTH(DW), .SN_FWD_ADDR_WIDTH(AW),
        .SN_INC_WIDTH(IW), .DROP_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en),
        .sn_byte_inc(sn_byte_inc), .sn_done(sn_done),
        .rdy_for_sn(rdy_for_sn), .rdy_for_sn_ack(rdy_for_sn_ack),
        .packet_dropped_inc(packet_dropped_inc),
        .ag_rdy_for_sn(ag_rdy_for_sn), .ag_rdy_for_sn_ack(ag_rdy_for_sn_ack),
        .ag_addr(ag_addr), .ag_wr_data(ag_wr_data), .ag_wr_en(ag_wr_en),
        .ag_byte_inc(ag_byte_inc), .ag_sn_done(ag_sn_done),
        .sel(sel), .drop_count(drop_count)
    );

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       wr;
        logic       done;
        logic       e_rdy;
        logic [3:0] e_ack;
        logic [3:0] e_wr;
        logic [3:0] e_done;
        logic [1:0] e_sel;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic ack, input logic wr, input logic done,
                         input logic drop);
        ag_rdy_for_sn      = req;
        rdy_for_sn_ack     = ack;
        sn_wr_en           = wr;
        sn_done            = done;
        packet_dropped_inc = drop;
    endtask

    task automatic set_vec(input int i, input logic [3:0] req, input logic ack, input logic wr,
                           input logic done, input logic e_rdy, input logic [3:0] e_ack,
                           input logic [3:0] e_wr, input logic [3:0] e_done, input logic [1:0] e_sel);
        vecs[i] = '{req, ack, wr, done, e_rdy, e_ack, e_wr, e_done, e_sel};
    endtask

    // Runs one packet with all agents requesting; expects the grant to go to exp_sel.
    task automatic do_packet(input logic [1:0] exp_sel, input int n_wr);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << exp_sel;
        drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !rdy_for_sn; i++) tick();
        chk("offer_up", 64'(rdy_for_sn), 64'd1);
        chk("grant_sel", 64'(sel), 64'(exp_sel));
        rdy_for_sn_ack = 1'b1;
        #1;
        chk("ack_onehot", 64'(ag_rdy_for_sn_ack), 64'(one_hot));
        tick();
        rdy_for_sn_ack = 1'b0;
        ag_rdy_for_sn  = 4'b1111 & ~one_hot;
        for (int k = 0; k < n_wr; k++) begin
            sn_wr_en    = 1'b1;
            sn_wr_data  = {32'hA5A5_0000 | 32'(exp_sel), 32'(k)};
            sn_addr     = AW'(k * 3 + 1);
            sn_byte_inc = IW'(k);
            #1;
            chk("wr_en", 64'(ag_wr_en), 64'(one_hot));
            chk("wr_data", ag_wr_data[int'(exp_sel)*DW +: DW], {32'hA5A5_0000 | 32'(exp_sel), 32'(k)});
            chk("wr_addr", 64'(ag_addr[int'(exp_sel)*AW +: AW]), 64'(k * 3 + 1));
            tick();
        end
        sn_wr_en = 1'b0;
        sn_done  = 1'b1;
        #1;
        chk("done_onehot", 64'(ag_sn_done), 64'(one_hot));
        tick();
        sn_done = 1'b0;
    endtask

    initial begin
        // Single-agent packet with stray inputs in IDLE/OFFER
        set_vec(0,  4'b0000, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        set_vec(1,  4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        set_vec(2,  4'b0001, 0, 1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        set_vec(3,  4'b0001, 0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        set_vec(4,  4'b0001, 1, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 2'd0);
        for (int i = 5; i <= 12; i++)
            set_vec(i, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000, 2'd0);
        set_vec(13, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 2'd0);
        set_vec(14, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        // Agent 2, ack and sn_done together in OFFER
        set_vec(15, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        set_vec(16, 4'b0100, 1, 0, 1, 1, 4'b0100, 4'b0000, 4'b0000, 2'd2);
        set_vec(17, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd2);
        set_vec(18, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0100, 2'd2);
        // Sparse 0101 after agent 2: wraps to 0, then 2
        set_vec(19, 4'b0101, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd2);
        set_vec(20, 4'b0101, 0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        set_vec(21, 4'b0101, 1, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 2'd0);
        set_vec(22, 4'b0100, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 2'd0);
        set_vec(23, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        set_vec(24, 4'b0100, 1, 0, 0, 1, 4'b0100, 4'b0000, 4'b0000, 2'd2);
        set_vec(25, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0100, 2'd2);
        set_vec(26, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd2);

        rst         = 1'b0;
        sn_addr     = 9'h1AB;
        sn_wr_data  = 64'hDEAD_BEEF_0123_4567;
        sn_byte_inc = 3'd5;
        drive(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_rdy", 64'(rdy_for_sn), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_ag_ctl", 64'({ag_rdy_for_sn_ack, ag_wr_en, ag_sn_done}), 64'd0);
        chk("rst_ag_bus", 64'(|{ag_addr, ag_wr_data, ag_byte_inc}), 64'd0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].req, vecs[i].ack, vecs[i].wr, vecs[i].done, 1'b0);
            #1;
            n_cmp++;
            if ({rdy_for_sn, ag_rdy_for_sn_ack, ag_wr_en, ag_sn_done, sel} !==
                {vecs[i].e_rdy, vecs[i].e_ack, vecs[i].e_wr, vecs[i].e_done, vecs[i].e_sel}) begin
                n_bad++;
                $display("FAIL vec[%0d]: got rdy=%b ack=%b wr=%b done=%b sel=%0d expected rdy=%b ack=%b wr=%b done=%b sel=%0d",
                         i, rdy_for_sn, ag_rdy_for_sn_ack, ag_wr_en, ag_sn_done, sel,
                         vecs[i].e_rdy, vecs[i].e_ack, vecs[i].e_wr, vecs[i].e_done, vecs[i].e_sel);
            end
            tick();
        end

        // Drop counter: 5 pulses, then 15 more saturate at 15 and hold
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("drop_5", 64'(drop_count), 64'd5);
        for (int i = 0; i < 15; i++) tick();
        chk("drop_sat", 64'(drop_count), 64'd15);
        packet_dropped_inc = 1'b0;
        tick();
        chk("drop_hold", 64'(drop_count), 64'd15);

        // Reset in BUSY after 3 writes; last was 2 so agent 1 (only requester) is served
        drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !rdy_for_sn; i++) tick();
        chk("mid_offer", 64'(rdy_for_sn), 64'd1);
        chk("mid_sel", 64'(sel), 64'd1);
        rdy_for_sn_ack = 1'b1;
        tick();
        drive(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk("mid_wr", 64'(ag_wr_en), 64'b0010);
        rst = 1'b0;
        #1;
        chk("mid_rst_wr", 64'(ag_wr_en), 64'd0);
        chk("mid_rst_bus", 64'(|{ag_addr, ag_wr_data, ag_byte_inc}), 64'd0);
        chk("mid_rst_drop", 64'(drop_count), 64'd0);
        sn_done = 1'b1;
        #1;
        chk("mid_rst_done", 64'(ag_sn_done), 64'd0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Round-robin fairness from reset priority: 0,1,2,3,0,1,2,3
        for (int p = 0; p < 8; p++) do_packet(2'(p % 4), 2 + p % 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
